encoder_nx_prio_seq: RTL and testbench

//  Parametrised, registered N-to-log2(N) request encoder. Successor to the 4x2 one-hot encoder.

---
 rtl/encoder_nx_prio_seq_if.sv | 20 ++
 rtl/encoder_nx_prio_seq.sv | 103 ++++++++++
 tb/tb_encoder_nx_prio_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/encoder_nx_prio_seq_if.sv
// Output handshake bundle for encoder_nx_prio_seq: one index per accepted beat.
interface encoder_nx_prio_seq_if #(
    parameter int W = 3
);
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;

    modport master (
        output out_valid,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        output out_ready
    );
endinterface

// File: rtl/encoder_nx_prio_seq.sv
// Registered N-request encoder with pending set and valid/ready output stage.
// Define ENC_RR_PRIORITY_EN for round-robin select instead of fixed priority.
module encoder_nx_prio_seq #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b0,
    localparam int W        = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          req_i,
    encoder_nx_prio_seq_if.master out,
    output logic [N-1:0]          pending_o,
    output logic                  merge_o,
    output logic                  idle_o
);
    logic [N-1:0] pending_q;
    logic         valid_q;
    logic [W-1:0] idx_q;
    logic         merge_q;
    logic [N-1:0] sel;
    logic [N-1:0] clr;
    logic [W-1:0] grant;
    logic         found;
    logic         load;

    assign load = ~valid_q | out.out_ready;

`ifdef ENC_RR_PRIORITY_EN
    logic [W-1:0] ptr_q;

    // Search upward from the pointer, wrapping N-1 -> 0.
    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = int'(ptr_q) + k;
            if (j >= N) j = j - N;
            if (!found && pending_q[j]) begin
                found = 1'b1;
                grant = W'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (load && found) begin
            ptr_q <= (grant == W'(N - 1)) ? '0 : grant + W'(1);
        end
    end
`else
    always_comb begin
        found = 1'b0;
        grant = '0;
        if (MSB_FIRST) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (!found && pending_q[i]) begin
                    found = 1'b1;
                    grant = W'(i);
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!found && pending_q[i]) begin
                    found = 1'b1;
                    grant = W'(i);
                end
            end
        end
    end
`endif

    always_comb begin
        sel = '0;
        if (found) sel[grant] = 1'b1;
        clr = load ? sel : '0;
    end

    // A new request on a bit being cleared this cycle wins: it is a new event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            merge_q   <= 1'b0;
        end else begin
            pending_q <= (pending_q & ~clr) | req_i;
            merge_q   <= |(req_i & pending_q & ~clr);
            if (load) begin
                valid_q <= found;
                if (found) idx_q <= grant;
            end
        end
    end

    assign out.out_valid = valid_q;
    assign out.out_idx   = idx_q;
    assign pending_o     = pending_q;
    assign merge_o       = merge_q;
    assign idle_o        = ~valid_q & ~(|pending_q);
endmodule

// File: tb/tb_encoder_nx_prio_seq.sv
// Directed bench for encoder_nx_prio_seq: N=8, plus a MSB_FIRST=1 twin.
module tb_encoder_nx_prio_seq;
    localparam int N = 8;
    localparam int W = 3;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] pend_a, pend_b;
    logic         merge_a, merge_b;
    logic         idle_a, idle_b;
    int           n_chk;
    int           n_err;

    encoder_nx_prio_seq_if #(.W(W)) ifa ();
    encoder_nx_prio_seq_if #(.W(W)) ifb ();

    encoder_nx_prio_seq #(.N(N), .MSB_FIRST(1'b0)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req),
        .out       (ifa.master),
        .pending_o (pend_a),
        .merge_o   (merge_a),
        .idle_o    (idle_a)
    );

    encoder_nx_prio_seq #(.N(N), .MSB_FIRST(1'b1)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req),
        .out       (ifb.master),
        .pending_o (pend_b),
        .merge_o   (merge_b),
        .idle_o    (idle_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned obs,
                       input int unsigned exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        req           = '0;
        ifa.out_ready = 1'b0;
        ifb.out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_ready(input logic r);
        ifa.out_ready = r;
        ifb.out_ready = r;
    endtask

    int exp_a6[6];
    int exp_b6[6];
    int seq_a[4];
    int seq_b[4];

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        req   = '0;
        set_ready(1'b0);

        // reset state
        @(negedge clk);
        chk("rst_valid", ifa.out_valid, 0);
        chk("rst_idx", ifa.out_idx, 0);
        chk("rst_pend", pend_a, 0);
        chk("rst_merge", merge_a, 0);
        chk("rst_idle", idle_a, 1);
        rst_n = 1'b1;

        // 1: single request
        do_reset();
        set_ready(1'b1);
        req = 8'h10;
        @(negedge clk);
        chk("t1_pend", pend_a, 8'h10);
        chk("t1_lat_valid", ifa.out_valid, 0);
        req = '0;
        @(negedge clk);
        chk("t1_valid", ifa.out_valid, 1);
        chk("t1_idx", ifa.out_idx, 4);
        @(negedge clk);
        chk("t1_valid_drop", ifa.out_valid, 0);
        chk("t1_idle", idle_a, 1);

        // 2: burst, both priority directions
        seq_a = '{0, 2, 5, 7};
`ifdef ENC_RR_PRIORITY_EN
        seq_b = '{0, 2, 5, 7};
`else
        seq_b = '{7, 5, 2, 0};
`endif
        do_reset();
        set_ready(1'b1);
        req = 8'hA5;
        @(negedge clk);
        req = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_valid", ifa.out_valid, 1);
            chk("t2_idx_a", ifa.out_idx, seq_a[i]);
            chk("t2_idx_b", ifb.out_idx, seq_b[i]);
        end
        @(negedge clk);
        chk("t2_end_a", ifa.out_valid, 0);
        chk("t2_end_b", ifb.out_valid, 0);

        // 3: backpressure and merge
        do_reset();
        req = 8'h05;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        chk("t3_valid", ifa.out_valid, 1);
        chk("t3_idx", ifa.out_idx, 0);
        chk("t3_pend", pend_a, 8'h04);
        @(negedge clk);
        chk("t3_hold_idx", ifa.out_idx, 0);
        chk("t3_hold_valid", ifa.out_valid, 1);
        req = 8'h04;
        @(negedge clk);
        chk("t3_merge", merge_a, 1);
        chk("t3_pend2", pend_a, 8'h04);
        req = '0;
        @(negedge clk);
        chk("t3_merge_off", merge_a, 0);
        chk("t3_idx_still", ifa.out_idx, 0);
        set_ready(1'b1);
        @(negedge clk);
        chk("t3_idx2_valid", ifa.out_valid, 1);
        chk("t3_idx2", ifa.out_idx, 2);
        @(negedge clk);
        chk("t3_done", ifa.out_valid, 0);
        chk("t3_idle", idle_a, 1);

        // 4: set/clear collision on bit 0
        do_reset();
        set_ready(1'b1);
        req = 8'h01;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_valid", ifa.out_valid, 1);
            chk("t4_idx", ifa.out_idx, 0);
            chk("t4_pend0", pend_a[0], 1);
            chk("t4_merge", merge_a, 0);
        end

        // 5: asynchronous reset mid-operation
        do_reset();
        req = 8'hFF;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        chk("t5_pre_valid", ifa.out_valid, 1);
        chk("t5_pre_pend", pend_a, 8'hFE);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_valid", ifa.out_valid, 0);
        chk("t5_idx", ifa.out_idx, 0);
        chk("t5_pend", pend_a, 0);
        chk("t5_merge", merge_a, 0);
        chk("t5_idle", idle_a, 1);
        @(negedge clk);
        rst_n = 1'b1;
        set_ready(1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_no_deliv", ifa.out_valid, 0);
        end

        // 6: fairness
`ifdef ENC_RR_PRIORITY_EN
        exp_a6 = '{0, 7, 0, 7, 0, 7};
        exp_b6 = '{0, 7, 0, 7, 0, 7};
`else
        exp_a6 = '{0, 0, 0, 0, 0, 0};
        exp_b6 = '{7, 7, 7, 7, 7, 7};
`endif
        do_reset();
        set_ready(1'b1);
        req = 8'h81;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_valid", ifa.out_valid, 1);
            chk("t6_idx_a", ifa.out_idx, exp_a6[i]);
            chk("t6_idx_b", ifb.out_idx, exp_b6[i]);
        end
        req = '0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
